// File: rtl/decode_pkg.sv
// Shared types for the MIPS decode stage: operation enum, encoding constants
// and the decoded-entry record carried through the output queue.
package decode_pkg;

  // Primary opcodes (insn[0:5])
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_REGIMM  = 6'h01;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06;
  localparam logic [5:0] OPC_BGTZ    = 6'h07;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  // SPECIAL funct codes (insn[26:31])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM selectors in the rt field
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // OP_NOP is encoded as zero so a cleared entry reads back as a NOP
  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_ADDIU, OP_SLTI, OP_LW, OP_SW, OP_LUI, OP_ORI, OP_J,
    OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_BLTZ, OP_BGEZ, OP_ILLEGAL
  } decode_op_t;

  typedef struct packed {
    decode_op_t  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [4:0]  dest_reg;
    logic        dest_we;
    logic [31:0] imm_ext;
    logic [31:0] target;
    logic [31:0] pc;
    logic        illegal;
  } decode_entry_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = decode stage view, master = producer/consumer (testbench) view.
interface decode_if;
  import decode_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [0:31] insn;       // bit 0 is the MSB
  logic [31:0] pc;
  logic        flush;

  logic        out_valid;
  logic        out_ready;
  decode_op_t  out_op;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [4:0]  out_dest_reg;
  logic        out_dest_we;
  logic [31:0] out_imm_ext;
  logic [31:0] out_target;
  logic [31:0] out_pc;
  logic        out_illegal;

  modport slave (
    input  in_valid, insn, pc, flush, out_ready,
    output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_dest_reg, out_dest_we, out_imm_ext, out_target, out_pc, out_illegal
  );

  modport master (
    output in_valid, insn, pc, flush, out_ready,
    input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_dest_reg, out_dest_we, out_imm_ext, out_target, out_pc, out_illegal
  );

endinterface

// File: rtl/decode_fifo.sv
// In-order queue of decoded entries, DEPTH a power of two. Flush empties it
// and overrides push/pop; no push-through when full.
module decode_fifo
  import decode_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  decode_entry_t push_data_i,
  input  logic          pop_i,
  output decode_entry_t head_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  decode_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; cleared on reset so the idle head reads all-zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// MIPS decode stage: combinational decode of the offered insn, result
// buffered in decode_fifo. Define DECODE_STATS_EN to add the
// insn_count / illegal_count statistics counters and ports.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef DECODE_STATS_EN
  output logic [COUNT_W-1:0] insn_count,
  output logic [COUNT_W-1:0] illegal_count,
`endif
  decode_if.slave            bus
);
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("decode_pipe: COUNT_W must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_pipe: DEPTH must be a power of two >= 2");
  end

  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm;
  logic [25:0] idx;
  logic [31:0] sext, pc4;
  decode_op_t    op;
  decode_entry_t ent, head;
  logic          full, empty, accept;

  assign opc  = bus.insn[0:5];
  assign rs   = bus.insn[6:10];
  assign rt   = bus.insn[11:15];
  assign rd   = bus.insn[16:20];
  assign sh   = bus.insn[21:25];
  assign fn   = bus.insn[26:31];
  assign imm  = bus.insn[16:31];
  assign idx  = bus.insn[6:31];
  assign sext = {{16{imm[15]}}, imm};
  assign pc4  = bus.pc + 32'd4;

  // Opcode/funct to operation; anything unlisted is illegal
  always_comb begin
    op = OP_ILLEGAL;
    case (opc)
      OPC_SPECIAL: begin
        if (bus.insn == '0) op = OP_NOP;
        else begin
          case (fn)
            FN_ADD:  op = OP_ADD;
            FN_ADDU: op = OP_ADDU;
            FN_SUB:  op = OP_SUB;
            FN_SUBU: op = OP_SUBU;
            FN_SLT:  op = OP_SLT;
            FN_SLTU: op = OP_SLTU;
            FN_SLL:  op = OP_SLL;
            FN_SRL:  op = OP_SRL;
            FN_SRA:  op = OP_SRA;
            FN_AND:  op = OP_AND;
            FN_OR:   op = OP_OR;
            FN_XOR:  op = OP_XOR;
            FN_NOR:  op = OP_NOR;
            default: op = OP_ILLEGAL;
          endcase
        end
      end
      OPC_REGIMM: begin
        if (rt == RT_BLTZ)      op = OP_BLTZ;
        else if (rt == RT_BGEZ) op = OP_BGEZ;
      end
      OPC_J:     op = OP_J;
      OPC_BEQ:   op = OP_BEQ;
      OPC_BNE:   op = OP_BNE;
      OPC_BLEZ:  op = OP_BLEZ;
      OPC_BGTZ:  op = OP_BGTZ;
      OPC_ADDIU: op = OP_ADDIU;
      OPC_SLTI:  op = OP_SLTI;
      OPC_ORI:   op = OP_ORI;
      OPC_LUI:   op = OP_LUI;
      OPC_LW:    op = OP_LW;
      OPC_SW:    op = OP_SW;
      default:   op = OP_ILLEGAL;
    endcase
  end

  // Build the queued entry: destination, immediate extension, target
  always_comb begin
    ent          = '0;
    ent.op       = op;
    ent.rs       = rs;
    ent.rt       = rt;
    ent.rd       = rd;
    ent.shamt    = sh;
    ent.pc       = bus.pc;
    ent.illegal  = (op == OP_ILLEGAL);
    ent.imm_ext  = sext;
    case (op)
      OP_ORI: ent.imm_ext = {16'h0000, imm};
      OP_LUI: ent.imm_ext = {imm, 16'h0000};
      default: ;
    endcase
    case (op)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
      OP_SRA, OP_AND, OP_OR, OP_XOR, OP_NOR: begin
        ent.dest_reg = rd;
        ent.dest_we  = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_LW, OP_LUI, OP_ORI: begin
        ent.dest_reg = rt;
        ent.dest_we  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_BLTZ, OP_BGEZ:
        ent.target = pc4 + {sext[29:0], 2'b00};
      OP_J:
        ent.target = {pc4[31:28], idx, 2'b00};
      default: ;
    endcase
  end

  assign accept       = bus.in_valid && !full && !bus.flush;
  assign bus.in_ready = !full;
  assign bus.out_valid = !empty;

  decode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush_i     (bus.flush),
    .push_i      (bus.in_valid),
    .push_data_i (ent),
    .pop_i       (bus.out_ready),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign bus.out_op       = head.op;
  assign bus.out_rs       = head.rs;
  assign bus.out_rt       = head.rt;
  assign bus.out_rd       = head.rd;
  assign bus.out_shamt    = head.shamt;
  assign bus.out_dest_reg = head.dest_reg;
  assign bus.out_dest_we  = head.dest_we;
  assign bus.out_imm_ext  = head.imm_ext;
  assign bus.out_target   = head.target;
  assign bus.out_pc       = head.pc;
  assign bus.out_illegal  = head.illegal;

`ifdef DECODE_STATS_EN
  logic [COUNT_W-1:0] insn_cnt_q, ill_cnt_q;

  // Statistics: count accepted and accepted-illegal insns; only reset clears
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      insn_cnt_q <= '0;
      ill_cnt_q  <= '0;
    end else if (accept) begin
      insn_cnt_q <= insn_cnt_q + COUNT_W'(1);
      if (ent.illegal) ill_cnt_q <= ill_cnt_q + COUNT_W'(1);
    end
  end

  assign insn_count    = insn_cnt_q;
  assign illegal_count = ill_cnt_q;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: table of decode vectors through a
// scoreboard, plus hand sequences for backpressure, flush and reset.
module tb_decode_pipe;
  import decode_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  decode_if bus();
`ifdef DECODE_STATS_EN
  logic [31:0] insn_count, illegal_count;
`endif

  decode_pipe #(.DEPTH(2), .COUNT_W(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
`ifdef DECODE_STATS_EN
    .insn_count    (insn_count),
    .illegal_count (illegal_count),
`endif
    .bus           (bus)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    decode_op_t  op;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic        we;
    logic [31:0] imm, tgt;
    logic        ill;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];
  vec_t sb [$];
  vec_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   acc;

  function automatic vec_t mk(logic [31:0] insn, logic [31:0] pc, decode_op_t op,
                              int rs, int rt, int rd, int sh, int dst, bit we,
                              logic [31:0] imm, logic [31:0] tgt, bit ill);
    vec_t v;
    v.insn = insn; v.pc = pc; v.op = op;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.sh = 5'(sh); v.dst = 5'(dst);
    v.we = we; v.imm = imm; v.tgt = tgt; v.ill = ill;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Observe the handshake just before the next active edge
  task automatic mon();
    vec_t e;
    if (bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pop: got pc=%h want no output", bus.out_pc);
      end else begin
        e = sb.pop_front();
        if (bus.out_op !== e.op || bus.out_rs !== e.rs || bus.out_rt !== e.rt ||
            bus.out_rd !== e.rd || bus.out_shamt !== e.sh || bus.out_dest_reg !== e.dst ||
            bus.out_dest_we !== e.we || bus.out_imm_ext !== e.imm ||
            bus.out_target !== e.tgt || bus.out_pc !== e.pc || bus.out_illegal !== e.ill) begin
          n_err++;
          $display("FAIL decode insn=%h: got op=%0d rs=%0d rt=%0d rd=%0d sh=%0d dst=%0d we=%b imm=%h tgt=%h pc=%h ill=%b want op=%0d rs=%0d rt=%0d rd=%0d sh=%0d dst=%0d we=%b imm=%h tgt=%h pc=%h ill=%b",
                   e.insn, bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
                   bus.out_dest_reg, bus.out_dest_we, bus.out_imm_ext, bus.out_target,
                   bus.out_pc, bus.out_illegal, e.op, e.rs, e.rt, e.rd, e.sh, e.dst, e.we,
                   e.imm, e.tgt, e.pc, e.ill);
        end
      end
    end
    if (bus.in_valid && bus.in_ready && !bus.flush) begin
      sb.push_back(cur);
      acc = 1'b1;
    end
  endtask

  // One clock: monitor at the falling edge, return #1 after the rising edge
  task automatic cyc();
    @(negedge clock);
    mon();
    @(posedge clock);
    #1;
  endtask

  task automatic send(int i);
    cur = tbl[i];
    bus.insn = tbl[i].insn;
    bus.pc = tbl[i].pc;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cyc();
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got no accept want accept of insn %h", tbl[i].insn);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while ((sb.size() != 0 || bus.out_valid) && k < 50) begin
      cyc();
      k++;
    end
    if (k == 50) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    sb.delete();
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(32'h00221820, 32'h00000100, OP_ADD,     1, 2,  3,  0, 3, 1, 32'h00001820, 32'h0, 0);
    tbl[1]  = mk(32'h2405FFFF, 32'h00000104, OP_ADDIU,   0, 5, 31, 31, 5, 1, 32'hFFFFFFFF, 32'h0, 0);
    tbl[2]  = mk(32'h3405FFFF, 32'h00000108, OP_ORI,     0, 5, 31, 31, 5, 1, 32'h0000FFFF, 32'h0, 0);
    tbl[3]  = mk(32'h3C051234, 32'h0000010C, OP_LUI,     0, 5,  2,  8, 5, 1, 32'h12340000, 32'h0, 0);
    tbl[4]  = mk(32'h1022FFFF, 32'h00000200, OP_BEQ,     1, 2, 31, 31, 0, 0, 32'hFFFFFFFF, 32'h00000200, 0);
    tbl[5]  = mk(32'h08000040, 32'h10000000, OP_J,       0, 0,  0,  1, 0, 0, 32'h00000040, 32'h10000100, 0);
    tbl[6]  = mk(32'hFC000000, 32'h00000110, OP_ILLEGAL, 0, 0,  0,  0, 0, 0, 32'h00000000, 32'h0, 1);
    tbl[7]  = mk(32'h04020000, 32'h00000114, OP_ILLEGAL, 0, 2,  0,  0, 0, 0, 32'h00000000, 32'h0, 1);
    tbl[8]  = mk(32'h00000000, 32'h00000300, OP_NOP,     0, 0,  0,  0, 0, 0, 32'h00000000, 32'h0, 0);
    tbl[9]  = mk(32'h8C430008, 32'h00000040, OP_LW,      2, 3,  0,  0, 3, 1, 32'h00000008, 32'h0, 0);
    tbl[10] = mk(32'hAC430008, 32'h00000044, OP_SW,      2, 3,  0,  0, 0, 0, 32'h00000008, 32'h0, 0);
    tbl[11] = mk(32'h14220004, 32'h00001000, OP_BNE,     1, 2,  0,  0, 0, 0, 32'h00000004, 32'h00001014, 0);
    tbl[12] = mk(32'h04210003, 32'hFFFFFFF0, OP_BGEZ,    1, 1,  0,  0, 0, 0, 32'h00000003, 32'h00000000, 0);
    tbl[13] = mk(32'h0420FFFE, 32'h00000008, OP_BLTZ,    1, 0, 31, 31, 0, 0, 32'hFFFFFFFE, 32'h00000004, 0);
    tbl[14] = mk(32'h00031083, 32'h00000050, OP_SRA,     0, 3,  2,  2, 2, 1, 32'h00001083, 32'h0, 0);
    tbl[15] = mk(32'h00000001, 32'h00000054, OP_ILLEGAL, 0, 0,  0,  0, 0, 0, 32'h00000001, 32'h0, 1);
    tbl[16] = mk(32'h1C200002, 32'h00000020, OP_BGTZ,    1, 0,  0,  0, 0, 0, 32'h00000002, 32'h0000002C, 0);
    tbl[17] = mk(32'h0062202B, 32'h00000058, OP_SLTU,    3, 2,  4,  0, 4, 1, 32'h0000202B, 32'h0, 0);

    bus.in_valid = 1'b0; bus.insn = '0; bus.pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    cur = tbl[0];

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_op", 32'(bus.out_op), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_imm", bus.out_imm_ext, 32'd0);
    chk("rst_out_tgt", bus.out_target, 32'd0);
`ifdef DECODE_STATS_EN
    chk("rst_insn_count", insn_count, 32'd0);
    chk("rst_illegal_count", illegal_count, 32'd0);
`endif
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Latency: visible one cycle after the accepting edge
    send(0);
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // Decode table, streaming
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(i);
    drain();

    // Backpressure: DEPTH=2 fills, third insn held, then all emerge in order
    bus.out_ready = 1'b0;
    send(0);
    send(1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    cur = tbl[2]; bus.insn = tbl[2].insn; bus.pc = tbl[2].pc; bus.in_valid = 1'b1; acc = 1'b0;
    repeat (3) cyc();
    chk("full_held_not_accepted", 32'(acc), 32'd0);
    chk("stall_out_pc_stable", bus.out_pc, tbl[0].pc);
    chk("stall_out_op_stable", 32'(bus.out_op), 32'(tbl[0].op));
    bus.out_ready = 1'b1;
    send(2);
    drain();

    // Illegal encodings and statistics from a clean reset
    do_reset();
    send(6);
    send(7);
    drain();
`ifdef DECODE_STATS_EN
    chk("stats_insn_count", insn_count, 32'd2);
    chk("stats_illegal_count", illegal_count, 32'd2);
`endif

    // Flush with a simultaneous push, one then two entries queued
    for (int nq = 1; nq <= 2; nq++) begin
      bus.out_ready = 1'b0;
      for (int q = 0; q < nq; q++) send(9 + q);
      cur = tbl[11]; bus.insn = tbl[11].insn; bus.pc = tbl[11].pc;
      bus.in_valid = 1'b1; bus.flush = 1'b1;
      cyc();
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      sb.delete();
      chk($sformatf("flush%0d_out_valid", nq), 32'(bus.out_valid), 32'd0);
      chk($sformatf("flush%0d_in_ready", nq), 32'(bus.in_ready), 32'd1);
`ifdef DECODE_STATS_EN
      chk($sformatf("flush%0d_insn_count", nq), insn_count, 32'(2 + nq * (nq + 1) / 2));
      chk($sformatf("flush%0d_illegal_count", nq), illegal_count, 32'd2);
`endif
      bus.out_ready = 1'b1;
      repeat (2) cyc();
    end

    // Asynchronous reset with entries queued
    bus.out_ready = 1'b0;
    send(3);
    send(4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef DECODE_STATS_EN
    chk("arst_insn_count", insn_count, 32'd0);
    chk("arst_illegal_count", illegal_count, 32'd0);
`endif
    sb.delete();
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    send(5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
